// File: rtl/uart_rx.sv
// UART receiver: 3-stage input synchronizer, mid-bit sampling FSM, optional even/odd parity.
// Emits a one-cycle data_is_valid or rx_error pulse one cycle after the stop-bit sample.
module uart_rx #(
   parameter int unsigned INPUT_DATA_WIDTH = 8,
   parameter int unsigned PARITY_ENABLED   = 1,
   parameter int unsigned PARITY_TYPE      = 0,
   parameter int unsigned CLOCKS_PER_BIT   = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  serial_in,
   output logic [INPUT_DATA_WIDTH-1:0]           received_data,
   output logic                                  data_is_valid,
   output logic                                  rx_error,
   output logic [$clog2(INPUT_DATA_WIDTH+4)-1:0] state
);

   localparam int unsigned StateW = $clog2(INPUT_DATA_WIDTH + 4);
   localparam int unsigned CntW   = $clog2(CLOCKS_PER_BIT);
   localparam int unsigned BitW   = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;

   localparam logic [CntW-1:0] HalfLast  = CntW'(CLOCKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] FullLast  = CntW'(CLOCKS_PER_BIT - 1);
   localparam logic [BitW-1:0] LastBit   = BitW'(INPUT_DATA_WIDTH - 1);
   localparam logic            ParityOdd = (PARITY_TYPE != 0);

   // DATA_k states are StData0 + k and have no enumerator of their own.
   typedef enum logic [StateW-1:0] {
      StIdle   = StateW'(0),
      StStart  = StateW'(1),
      StData0  = StateW'(2),
      StParity = StateW'(INPUT_DATA_WIDTH + 2),
      StStop   = StateW'(INPUT_DATA_WIDTH + 3)
   } state_e;

   logic [2:0]                  sync_q;
   logic                        rx_s;
   logic                        rx_prev_q;
   logic                        armed_q;
   logic [StateW-1:0]           state_q;
   logic [CntW-1:0]             cnt_q;
   logic [BitW-1:0]             bit_q;
   logic [INPUT_DATA_WIDTH-1:0] shift_q;
   logic                        parity_bit_q;
   logic                        stop_seen_q;
   logic                        stop_bit_q;
   logic [INPUT_DATA_WIDTH-1:0] data_q;
   logic                        valid_q;
   logic                        error_q;
   logic                        parity_ok;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[1:0], serial_in};
      end
   end

   assign rx_s = sync_q[2];

   assign parity_ok = (PARITY_ENABLED == 0) ||
                      ((^shift_q ^ parity_bit_q ^ ParityOdd) == 1'b0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_prev_q    <= 1'b1;
         armed_q      <= 1'b0;
         state_q      <= StIdle;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         parity_bit_q <= 1'b0;
         stop_seen_q  <= 1'b0;
         stop_bit_q   <= 1'b0;
         data_q       <= '0;
         valid_q      <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         rx_prev_q <= rx_s;
         cnt_q     <= cnt_q + 1'b1;
         if (rx_s) begin
            armed_q <= 1'b1;
         end

         case (state_q)
            StIdle: begin
               cnt_q <= '0;
               if (armed_q && rx_prev_q && !rx_s) begin
                  state_q <= StStart;
                  bit_q   <= '0;
               end
            end

            StStart: begin
               if (cnt_q == HalfLast) begin
                  cnt_q   <= '0;
                  state_q <= rx_s ? StIdle : StData0;
               end
            end

            StParity: begin
               if (cnt_q == FullLast) begin
                  cnt_q        <= '0;
                  parity_bit_q <= rx_s;
                  state_q      <= StStop;
               end
            end

            StStop: begin
               // Sample on one edge, report on the next; the report edge is also the return to idle.
               if (stop_seen_q) begin
                  stop_seen_q <= 1'b0;
                  state_q     <= StIdle;
                  if (stop_bit_q && parity_ok) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                  end else begin
                     error_q <= 1'b1;
                     if (!stop_bit_q) begin
                        armed_q <= 1'b0;
                     end
                  end
               end else if (cnt_q == FullLast) begin
                  stop_seen_q <= 1'b1;
                  stop_bit_q  <= rx_s;
               end
            end

            default: begin
               if (state_q > StStop) begin
                  state_q <= StIdle;
               end else if (cnt_q == FullLast) begin
                  cnt_q          <= '0;
                  shift_q[bit_q] <= rx_s;
                  bit_q          <= bit_q + 1'b1;
                  if (bit_q == LastBit) begin
                     state_q <= (PARITY_ENABLED != 0) ? StParity : StStop;
                  end else begin
                     state_q <= state_q + 1'b1;
                  end
               end
            end
         endcase
      end
   end

   assign received_data = data_q;
   assign data_is_valid = valid_q;
   assign rx_error      = error_q;
   assign state         = state_q;

   a_pulse_exclusive : assert property (@(posedge clk) disable iff (!reset)
      !(valid_q && error_q));

   a_state_range : assert property (@(posedge clk) disable iff (!reset)
      state_q <= StStop);

   a_valid_one_cycle : assert property (@(posedge clk) disable iff (!reset)
      valid_q |=> !valid_q);

   a_error_one_cycle : assert property (@(posedge clk) disable iff (!reset)
      error_q |=> !error_q);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus randomized frames
// checked against a frame-level model of data, parity, stop bit and pulse timing.
module tb_uart_rx;

   localparam int unsigned W   = 8;
   localparam int unsigned PE  = 1;
   localparam int unsigned PT  = 0;
   localparam int unsigned CPB = 8;
   localparam int          Latency  = 3 + CPB / 2 + (W + PE + 1) * CPB + 1;
   localparam int          FrameLen = (W + PE + 2) * CPB;

   logic                         clk = 1'b0;
   logic                         reset = 1'b1;
   logic                         serial_in = 1'b1;
   logic [W-1:0]                 received_data;
   logic                         data_is_valid;
   logic                         rx_error;
   logic [$clog2(W+4)-1:0]       state;

   uart_rx #(
      .INPUT_DATA_WIDTH (W),
      .PARITY_ENABLED   (PE),
      .PARITY_TYPE      (PT),
      .CLOCKS_PER_BIT   (CPB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .serial_in     (serial_in),
      .received_data (received_data),
      .data_is_valid (data_is_valid),
      .rx_error      (rx_error),
      .state         (state)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           v_cyc[$];
   logic [W-1:0] v_dat[$];
   int           e_cyc[$];
   int           both_cnt = 0;

   always @(negedge clk) begin
      if (data_is_valid) begin
         v_cyc.push_back(cyc);
         v_dat.push_back(received_data);
      end
      if (rx_error) e_cyc.push_back(cyc);
      if (data_is_valid && rx_error) both_cnt++;
   end

   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] exp_data = '0;

   // All drive tasks start and end #1 after a rising edge.
   task automatic drive_bit(input logic b);
      serial_in = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [W-1:0] d, input bit bad_par, input bit stop_b,
                             output int start);
      logic p;
      p = (^d) ^ (PT != 0);
      if (bad_par) p = ~p;
      start = cyc + 1;
      drive_bit(1'b0);
      for (int i = 0; i < W; i++) drive_bit(d[i]);
      if (PE != 0) drive_bit(p);
      drive_bit(stop_b);
   endtask

   task automatic clear_log();
      v_cyc.delete();
      v_dat.delete();
      e_cyc.delete();
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      #1;
      checks++; if (received_data !== '0) begin failures++;
         $display("FAIL reset_data: got %0h expected 0", received_data); end
      checks++; if (data_is_valid !== 1'b0) begin failures++;
         $display("FAIL reset_valid: got %0b expected 0", data_is_valid); end
      checks++; if (rx_error !== 1'b0) begin failures++;
         $display("FAIL reset_error: got %0b expected 0", rx_error); end
      checks++; if (state !== '0) begin failures++;
         $display("FAIL reset_state: got %0d expected 0", state); end
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      idle(10);
   endtask

   task automatic test_good_frame();
      int s;
      clear_log();
      send_frame(8'hA5, 1'b0, 1'b1, s);
      idle(16);
      exp_data = 8'hA5;
      checks++; if (v_cyc.size() != 1) begin failures++;
         $display("FAIL good_count: got %0d pulses expected 1", v_cyc.size()); end
      checks++; if (v_cyc.size() > 0 && v_cyc[0] != s + Latency) begin failures++;
         $display("FAIL good_latency: got %0d expected %0d", v_cyc[0] - s, Latency); end
      checks++; if (v_dat.size() > 0 && v_dat[0] !== exp_data) begin failures++;
         $display("FAIL good_pulse_data: got %0h expected %0h", v_dat[0], exp_data); end
      checks++; if (e_cyc.size() != 0) begin failures++;
         $display("FAIL good_no_error: got %0d error pulses expected 0", e_cyc.size()); end
      checks++; if (received_data !== exp_data) begin failures++;
         $display("FAIL good_data: got %0h expected %0h", received_data, exp_data); end
      checks++; if (state !== '0) begin failures++;
         $display("FAIL good_idle: got state %0d expected 0", state); end
   endtask

   task automatic test_parity_error();
      int s;
      clear_log();
      send_frame(8'h3C, 1'b1, 1'b1, s);
      idle(16);
      checks++; if (e_cyc.size() != 1) begin failures++;
         $display("FAIL parity_err_count: got %0d expected 1", e_cyc.size()); end
      checks++; if (e_cyc.size() > 0 && e_cyc[0] != s + Latency) begin failures++;
         $display("FAIL parity_err_time: got %0d expected %0d", e_cyc[0] - s, Latency); end
      checks++; if (v_cyc.size() != 0) begin failures++;
         $display("FAIL parity_no_valid: got %0d expected 0", v_cyc.size()); end
      checks++; if (received_data !== exp_data) begin failures++;
         $display("FAIL parity_keep_data: got %0h expected %0h", received_data, exp_data); end
   endtask

   task automatic test_framing_error();
      int s;
      clear_log();
      send_frame(8'h55, 1'b0, 1'b0, s);
      serial_in = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      idle(40);
      checks++; if (e_cyc.size() != 1) begin failures++;
         $display("FAIL frame_err_count: got %0d expected 1", e_cyc.size()); end
      checks++; if (e_cyc.size() > 0 && e_cyc[0] != s + Latency) begin failures++;
         $display("FAIL frame_err_time: got %0d expected %0d", e_cyc[0] - s, Latency); end
      checks++; if (v_cyc.size() != 0) begin failures++;
         $display("FAIL frame_no_valid: got %0d expected 0", v_cyc.size()); end
      checks++; if (state !== '0) begin failures++;
         $display("FAIL frame_idle: got state %0d expected 0", state); end
      checks++; if (received_data !== exp_data) begin failures++;
         $display("FAIL frame_keep_data: got %0h expected %0h", received_data, exp_data); end
   endtask

   task automatic test_false_start();
      clear_log();
      serial_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 serial_in = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (state !== 1) begin failures++;
         $display("FAIL false_start_enter: got state %0d expected 1", state); end
      repeat (5) @(posedge clk);
      @(negedge clk);
      checks++; if (state !== 0) begin failures++;
         $display("FAIL false_start_abort: got state %0d expected 0", state); end
      @(posedge clk);
      #1;
      idle(20);
      checks++; if (v_cyc.size() + e_cyc.size() != 0) begin failures++;
         $display("FAIL false_start_pulses: got %0d expected 0",
                  v_cyc.size() + e_cyc.size()); end
   endtask

   task automatic test_back_to_back();
      int s0, s1;
      clear_log();
      send_frame(8'h00, 1'b0, 1'b1, s0);
      send_frame(8'hFF, 1'b0, 1'b1, s1);
      idle(16);
      exp_data = 8'hFF;
      checks++; if (v_cyc.size() != 2) begin failures++;
         $display("FAIL b2b_count: got %0d expected 2", v_cyc.size()); end
      if (v_cyc.size() == 2) begin
         checks++; if (v_cyc[0] != s0 + Latency) begin failures++;
            $display("FAIL b2b_first_time: got %0d expected %0d", v_cyc[0] - s0, Latency); end
         checks++; if (v_cyc[1] - v_cyc[0] != FrameLen) begin failures++;
            $display("FAIL b2b_spacing: got %0d expected %0d", v_cyc[1] - v_cyc[0], FrameLen); end
         checks++; if (v_dat[0] !== 8'h00 || v_dat[1] !== 8'hFF) begin failures++;
            $display("FAIL b2b_data: got %0h,%0h expected 0,ff", v_dat[0], v_dat[1]); end
      end
      checks++; if (e_cyc.size() != 0) begin failures++;
         $display("FAIL b2b_no_error: got %0d expected 0", e_cyc.size()); end
   endtask

   task automatic test_reset_mid_frame();
      int s;
      clear_log();
      serial_in = 1'b0;
      repeat (40) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      checks++; if (received_data !== '0 || data_is_valid !== 1'b0 || rx_error !== 1'b0
                    || state !== '0) begin failures++;
         $display("FAIL midreset_outputs: got data=%0h v=%0b e=%0b st=%0d expected all 0",
                  received_data, data_is_valid, rx_error, state); end
      serial_in = 1'b1;
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      exp_data = '0;
      idle(30);
      checks++; if (v_cyc.size() + e_cyc.size() != 0) begin failures++;
         $display("FAIL midreset_ignored: got %0d pulses expected 0",
                  v_cyc.size() + e_cyc.size()); end
      send_frame(8'h81, 1'b0, 1'b1, s);
      idle(16);
      exp_data = 8'h81;
      checks++; if (v_cyc.size() != 1 || (v_cyc.size() == 1 && v_cyc[0] != s + Latency))
      begin failures++;
         $display("FAIL midreset_resume: got %0d pulses expected 1 at +%0d",
                  v_cyc.size(), Latency); end
      checks++; if (received_data !== exp_data) begin failures++;
         $display("FAIL midreset_data: got %0h expected %0h", received_data, exp_data); end
   endtask

   task automatic test_random();
      int           s, got;
      bit           bad_par, stop_b, exp_valid;
      logic [W-1:0] d;
      for (int i = 0; i < 12; i++) begin
         clear_log();
         d       = W'($urandom_range(0, (1 << W) - 1));
         bad_par = ($urandom_range(0, 3) == 0);
         stop_b  = ($urandom_range(0, 5) != 0);
         exp_valid = !bad_par && stop_b;
         send_frame(d, bad_par, stop_b, s);
         idle(12 + $urandom_range(0, 8));
         if (exp_valid) exp_data = d;
         checks++;
         if (v_cyc.size() != (exp_valid ? 1 : 0) || e_cyc.size() != (exp_valid ? 0 : 1)) begin
            failures++;
            $display("FAIL rand_kind[%0d]: got v=%0d e=%0d expected valid=%0b", i,
                     v_cyc.size(), e_cyc.size(), exp_valid);
         end
         got = -1;
         if (exp_valid && v_cyc.size() > 0) got = v_cyc[0] - s;
         if (!exp_valid && e_cyc.size() > 0) got = e_cyc[0] - s;
         checks++; if (got != Latency) begin failures++;
            $display("FAIL rand_time[%0d]: got %0d expected %0d", i, got, Latency); end
         checks++; if (received_data !== exp_data) begin failures++;
            $display("FAIL rand_data[%0d]: got %0h expected %0h", i, received_data, exp_data); end
      end
   endtask

   task automatic test_exclusive();
      checks++; if (both_cnt != 0) begin failures++;
         $display("FAIL pulse_exclusive: got %0d overlapping cycles expected 0", both_cnt); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_parity_error();
      test_framing_error();
      test_false_start();
      test_back_to_back();
      test_reset_mid_frame();
      test_random();
      test_exclusive();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
